// File: rtl/dma_rd_tag_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dma_rd_tag_ctrl
// Description : DMA read scheduler. Splits host read commands into memory-read
//               requests that never cross a MAX_RD_DW-dword boundary, allocates
//               one of 32 completion tags per request, tracks completion per
//               tag and streams each tag's buffered data out of the RX
//               completion RAM in issue order through a 2-entry skid FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module dma_rd_tag_ctrl #(
  parameter int MAX_RD_DW = 128,
  parameter int TAG_NUM   = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [63:0]  cmd_addr,
  input  logic [15:0]  cmd_len_dw,
  output logic         req_valid,
  input  logic         req_ready,
  output logic [63:0]  req_addr,
  output logic [10:0]  req_len,
  output logic [4:0]   req_tag,
  input  logic         tag_rc_done,
  input  logic [4:0]   tag_rc_number,
  output logic         ram_rd_en,
  output logic [12:0]  ram_rd_addr,
  input  logic [127:0] ram_rd_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic [3:0]   out_keep,
  output logic         out_last,
  output logic         busy
);
  localparam int LOG_MAX = $clog2(MAX_RD_DW);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_ISSUE = 1'b1} req_state_t;
  typedef enum logic [0:0] {R_IDLE = 1'b0, R_READ = 1'b1} rd_state_t;

  req_state_t         req_state_q;
  rd_state_t          rd_state_q;
  logic [63:0]        addr_q;
  logic [15:0]        rem_q;
  // Pointers carry one extra bit so their difference is the outstanding count.
  logic [5:0]         alloc_ptr_q, retire_ptr_q;
  logic [LOG_MAX:0]   tag_len_q [32];
  logic [31:0]        tag_last_q;
  logic [31:0]        valid_q, valid_d;
  logic [31:0]        done_q, done_d;
  logic [4:0]         row_q;
  logic [132:0]       fifo_q [2];
  logic               fifo_rd_q, fifo_wr_q;
  logic [1:0]         fifo_cnt_q;
  logic               inflight_q, inflight_last_q;
  logic [3:0]         inflight_keep_q;

  logic [5:0]         w_outstanding;
  logic [LOG_MAX-1:0] w_off;
  logic [10:0]        w_room, w_len;
  logic               w_req_fire;
  logic [4:0]         w_rtag;
  logic [LOG_MAX:0]   w_rlen;
  logic [4:0]         w_last_row;
  logic               w_row_last, w_retire, w_space;
  logic [3:0]         w_rd_keep;
  logic               w_rd_last;
  logic               w_sel_in, w_push, w_pop;

  // Request sizing: clip to the remaining length and to the next boundary.
  always_comb begin
    w_outstanding = alloc_ptr_q - retire_ptr_q;
    w_off         = addr_q[LOG_MAX+1:2];
    w_room        = 11'(MAX_RD_DW) - 11'(w_off);
    w_len         = (rem_q < 16'(w_room)) ? rem_q[10:0] : w_room;
  end

  assign cmd_ready  = (req_state_q == S_IDLE);
  assign req_valid  = (req_state_q == S_ISSUE) && (w_outstanding < 6'(TAG_NUM));
  assign req_addr   = addr_q;
  assign req_len    = w_len;
  assign req_tag    = alloc_ptr_q[4:0];
  assign w_req_fire = req_valid && req_ready;

  // Request FSM: latch a command, then issue boundary-aligned requests.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_state_q <= S_IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      alloc_ptr_q <= '0;
      tag_last_q  <= '0;
      for (int i = 0; i < 32; i++) tag_len_q[i] <= '0;
    end else begin
      case (req_state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            addr_q      <= cmd_addr & ~64'h3;
            rem_q       <= (cmd_len_dw == 16'd0) ? 16'd1 : cmd_len_dw;
            req_state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (w_req_fire) begin
            addr_q                       <= addr_q + {51'd0, w_len, 2'b00};
            rem_q                        <= rem_q - 16'(w_len);
            tag_len_q[alloc_ptr_q[4:0]]  <= w_len[LOG_MAX:0];
            tag_last_q[alloc_ptr_q[4:0]] <= (rem_q == 16'(w_len));
            alloc_ptr_q                  <= alloc_ptr_q + 6'd1;
            if (rem_q == 16'(w_len)) req_state_q <= S_IDLE;
          end
        end
        default: req_state_q <= S_IDLE;
      endcase
    end
  end

  // Readout row bookkeeping for the tag at the head of the issue order.
  always_comb begin
    w_rtag     = retire_ptr_q[4:0];
    w_rlen     = tag_len_q[w_rtag];
    w_last_row = 5'(((w_rlen + (LOG_MAX+1)'(3)) >> 2) - (LOG_MAX+1)'(1));
    w_row_last = (row_q == w_last_row);
    w_space    = ({1'b0, fifo_cnt_q} + {2'b00, inflight_q}) < 3'd2;
    ram_rd_en  = done_q[w_rtag] && w_space;
    w_retire   = ram_rd_en && w_row_last;
    w_rd_keep  = 4'b1111;
    w_rd_last  = 1'b0;
    if (w_row_last) begin
      case (w_rlen[1:0])
        2'd1:    w_rd_keep = 4'b0001;
        2'd2:    w_rd_keep = 4'b0011;
        2'd3:    w_rd_keep = 4'b0111;
        default: w_rd_keep = 4'b1111;
      endcase
      w_rd_last = tag_last_q[w_rtag];
    end
  end

  assign ram_rd_addr = {3'b000, w_rtag, row_q};

  // Outstanding and completed tag masks; a retire clears both bits.
  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    if (w_req_fire) valid_d[alloc_ptr_q[4:0]] = 1'b1;
    if (tag_rc_done && valid_q[tag_rc_number]) done_d[tag_rc_number] = 1'b1;
    if (w_retire) begin
      valid_d[w_rtag] = 1'b0;
      done_d[w_rtag]  = 1'b0;
    end
  end

  // Tag state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      done_q  <= '0;
    end else begin
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  // Readout FSM: walk the rows of the head tag, then retire it.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_q   <= R_IDLE;
      row_q        <= '0;
      retire_ptr_q <= '0;
    end else if (ram_rd_en) begin
      if (w_row_last) begin
        row_q        <= '0;
        retire_ptr_q <= retire_ptr_q + 6'd1;
        rd_state_q   <= R_IDLE;
      end else begin
        row_q      <= row_q + 5'd1;
        rd_state_q <= R_READ;
      end
    end
  end

  // Output path: RAM data is forwarded directly when the FIFO is empty.
  always_comb begin
    w_sel_in = (fifo_cnt_q == 2'd0) && inflight_q;
    w_pop    = (fifo_cnt_q != 2'd0) && out_ready;
    w_push   = inflight_q && !((fifo_cnt_q == 2'd0) && out_ready);
  end

  assign out_valid = (fifo_cnt_q != 2'd0) || inflight_q;
  assign {out_last, out_keep, out_data} =
      w_sel_in ? {inflight_last_q, inflight_keep_q, ram_rd_data} : fifo_q[fifo_rd_q];

  // Skid FIFO and in-flight read tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_q[0]       <= '0;
      fifo_q[1]       <= '0;
      fifo_rd_q       <= 1'b0;
      fifo_wr_q       <= 1'b0;
      fifo_cnt_q      <= '0;
      inflight_q      <= 1'b0;
      inflight_keep_q <= '0;
      inflight_last_q <= 1'b0;
    end else begin
      inflight_q      <= ram_rd_en;
      inflight_keep_q <= w_rd_keep;
      inflight_last_q <= w_rd_last;
      if (w_push) begin
        fifo_q[fifo_wr_q] <= {inflight_last_q, inflight_keep_q, ram_rd_data};
        fifo_wr_q         <= ~fifo_wr_q;
      end
      if (w_pop) fifo_rd_q <= ~fifo_rd_q;
      fifo_cnt_q <= fifo_cnt_q + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  assign busy = (req_state_q != S_IDLE) || (rd_state_q != R_IDLE) ||
                (w_outstanding != 6'd0) || (fifo_cnt_q != 2'd0) || inflight_q;

endmodule
`default_nettype wire

// File: tb/tb_dma_rd_tag_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dma_rd_tag_ctrl
// Description : Directed self-checking bench for dma_rd_tag_ctrl with a
//               one-cycle-latency RX RAM model and request/beat monitors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dma_rd_tag_ctrl;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0, cmd_ready;
  logic [63:0]  cmd_addr = '0;
  logic [15:0]  cmd_len_dw = '0;
  logic         req_valid, req_ready = 1'b1;
  logic [63:0]  req_addr;
  logic [10:0]  req_len;
  logic [4:0]   req_tag;
  logic         tag_rc_done = 1'b0;
  logic [4:0]   tag_rc_number = '0;
  logic         ram_rd_en;
  logic [12:0]  ram_rd_addr;
  logic [127:0] ram_rd_data = '0;
  logic         out_valid, out_ready = 1'b1;
  logic [127:0] out_data;
  logic [3:0]   out_keep;
  logic         out_last, busy;

  typedef struct packed { logic [127:0] d; logic [3:0] k; logic l; } beat_t;
  typedef struct packed { logic [63:0] a; logic [10:0] n; logic [4:0] t; } req_t;
  beat_t beats[$];
  req_t  reqs[$];
  int errors = 0;
  int checks = 0;

  always #4 clk = ~clk;

  dma_rd_tag_ctrl #(.MAX_RD_DW(128), .TAG_NUM(32)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len_dw(cmd_len_dw),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
    .req_tag(req_tag), .tag_rc_done(tag_rc_done), .tag_rc_number(tag_rc_number),
    .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_keep(out_keep),
    .out_last(out_last), .busy(busy)
  );

  // Every DW of a RAM row encodes the row address and its DW index.
  function automatic logic [127:0] pat(input logic [12:0] a);
    return {3'b000, a, 16'd3, 3'b000, a, 16'd2, 3'b000, a, 16'd1, 3'b000, a, 16'd0};
  endfunction

  // RX RAM model: data one cycle after the read enable.
  always @(posedge clk) ram_rd_data <= ram_rd_en ? pat(ram_rd_addr) : {4{32'hDEAD_BEEF}};

  // Handshake monitors.
  always @(negedge clk) begin
    if (req_valid && req_ready) reqs.push_back({req_addr, req_len, req_tag});
    if (out_valid && out_ready) beats.push_back({out_data, out_keep, out_last});
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; cmd_valid = 1'b0; tag_rc_done = 1'b0; out_ready = 1'b1; req_ready = 1'b1;
    tick(2);
    rst = 1'b0;
    beats.delete();
    reqs.delete();
  endtask

  task automatic send_cmd(input logic [63:0] a, input logic [15:0] l);
    logic got;
    got = 1'b0;
    cmd_addr = a; cmd_len_dw = l; cmd_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cmd_ready) begin got = 1'b1; break; end
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    if (!got) chk("cmd_accept_timeout", {127'd0, got}, 128'd1);
  endtask

  task automatic pulse(input logic [4:0] t);
    tag_rc_number = t; tag_rc_done = 1'b1;
    tick(1);
    tag_rc_done = 1'b0;
  endtask

  task automatic wait_reqs(input string tag, input int n);
    for (int i = 0; i < 500 && reqs.size() < n; i++) @(negedge clk);
    chk(tag, 128'(reqs.size()), 128'(n));
    tick(1);
  endtask

  task automatic wait_beats(input string tag, input int n);
    for (int i = 0; i < 500 && beats.size() < n; i++) @(negedge clk);
    chk(tag, 128'(beats.size()), 128'(n));
    tick(1);
  endtask

  logic [63:0] exp_a [4];
  logic [10:0] exp_n [4];
  int nlast, bad, rdc, acc, pend, maxpend, ov;
  logic [3:0] rdy_pat;

  initial begin
    // ---- reset values ----
    do_reset();
    @(negedge clk);
    chk("rst_cmd_ready", 128'(cmd_ready), 128'd1);
    chk("rst_req_valid", 128'(req_valid), 128'd0);
    chk("rst_req_fields", {59'd0, req_addr, req_len, req_tag}, 128'd0);
    chk("rst_ram_rd", {114'd0, ram_rd_en, ram_rd_addr}, 128'd0);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_out_data", out_data, 128'd0);
    chk("rst_out_keep_last", {123'd0, out_keep, out_last}, 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);

    // ---- single 4-DW command and completion latency ----
    tick(1);
    send_cmd(64'h1000, 16'd4);
    @(negedge clk);
    chk("t1_req_valid_next", 128'(req_valid), 128'd1);
    wait_reqs("t1_nreq", 1);
    chk("t1_req0", 128'({reqs[0].a, reqs[0].n, reqs[0].t}), 128'({64'h1000, 11'd4, 5'd0}));
    pulse(5'd0);
    @(negedge clk);
    chk("t1_rd_en_T1", {114'd0, ram_rd_en, ram_rd_addr}, {114'd0, 1'b1, 13'd0});
    @(posedge clk); #1;
    @(negedge clk);
    chk("t1_out_valid_T2", 128'(out_valid), 128'd1);
    chk("t1_out_data", out_data, pat(13'd0));
    chk("t1_out_keep_last", {123'd0, out_keep, out_last}, {123'd0, 4'b1111, 1'b1});
    tick(3);
    @(negedge clk);
    chk("t1_busy_clear", 128'(busy), 128'd0);

    // ---- boundary split: 300 DW at 0x1F0 ----
    do_reset();
    send_cmd(64'h1F0, 16'd300);
    wait_reqs("t2_nreq", 4);
    exp_a[0] = 64'h1F0; exp_a[1] = 64'h200; exp_a[2] = 64'h400; exp_a[3] = 64'h600;
    exp_n[0] = 11'd4;   exp_n[1] = 11'd128; exp_n[2] = 11'd128; exp_n[3] = 11'd40;
    for (int i = 0; i < 4; i++)
      chk($sformatf("t2_req%0d", i), 128'({reqs[i].a, reqs[i].n, reqs[i].t}),
          128'({exp_a[i], exp_n[i], 5'(i)}));
    for (int i = 0; i < 4; i++) pulse(5'(i));
    wait_beats("t2_nbeats", 75);
    nlast = 0;
    foreach (beats[i]) if (beats[i].l) nlast++;
    chk("t2_num_last", 128'(nlast), 128'd1);
    chk("t2_final_beat", {123'd0, beats[74].k, beats[74].l}, {123'd0, 4'b1111, 1'b1});
    chk("t2_beat1_data", beats[1].d, pat({5'd1, 5'd0}));
    chk("t2_beat32_data", beats[32].d, pat({5'd1, 5'd31}));
    chk("t2_beat74_data", beats[74].d, pat({5'd3, 5'd9}));

    // ---- out-of-order completions, in-order output ----
    do_reset();
    send_cmd(64'h0, 16'd5);
    send_cmd(64'h100, 16'd6);
    send_cmd(64'h200, 16'd7);
    wait_reqs("t3_nreq", 3);
    chk("t3_req2", 128'({reqs[2].a, reqs[2].n, reqs[2].t}), 128'({64'h200, 11'd7, 5'd2}));
    pulse(5'd2);
    tick(10);
    chk("t3_hold_for_tag0", 128'(beats.size()), 128'd0);
    pulse(5'd0);
    wait_beats("t3_tag0_beats", 2);
    tick(5);
    chk("t3_hold_for_tag1", 128'(beats.size()), 128'd2);
    pulse(5'd1);
    wait_beats("t3_all_beats", 6);
    chk("t3_b0", {123'd0, beats[0].k, beats[0].l}, {123'd0, 4'b1111, 1'b0});
    chk("t3_b1", {123'd0, beats[1].k, beats[1].l}, {123'd0, 4'b0001, 1'b1});
    chk("t3_b2_data", beats[2].d, pat({5'd1, 5'd0}));
    chk("t3_b3", {123'd0, beats[3].k, beats[3].l}, {123'd0, 4'b0011, 1'b1});
    chk("t3_b4_data", beats[4].d, pat({5'd2, 5'd0}));
    chk("t3_b5", {123'd0, beats[5].k, beats[5].l}, {123'd0, 4'b0111, 1'b1});

    // ---- tag pool exhaustion and wrap ----
    do_reset();
    for (int i = 0; i < 33; i++) send_cmd(64'(4 * i), 16'd1);
    tick(5);
    @(negedge clk);
    chk("t4_stall_nreq", 128'(reqs.size()), 128'd32);
    chk("t4_stall_req_valid", 128'(req_valid), 128'd0);
    chk("t4_req31_tag", 128'(reqs[31].t), 128'd31);
    chk("t4_busy", 128'(busy), 128'd1);
    tick(1);
    pulse(5'd0);
    wait_reqs("t4_wrap_nreq", 33);
    chk("t4_req32", 128'({reqs[32].a, reqs[32].n, reqs[32].t}), 128'({64'h80, 11'd1, 5'd0}));
    chk("t4_beats", 128'(beats.size()), 128'd1);
    chk("t4_beat0", {123'd0, beats[0].k, beats[0].l}, {123'd0, 4'b0001, 1'b1});

    // ---- back-pressure 1-0-0-1 during a 32-beat tag ----
    do_reset();
    send_cmd(64'h0, 16'd128);
    wait_reqs("t5_nreq", 1);
    pulse(5'd0);
    rdy_pat = 4'b1001;
    rdc = 0; acc = 0; maxpend = 0;
    for (int c = 0; c < 400 && acc < 32; c++) begin
      out_ready = rdy_pat[c % 4];
      @(negedge clk);
      if (ram_rd_en) rdc++;
      if (out_valid && out_ready) acc++;
      pend = rdc - acc;
      if (pend > maxpend) maxpend = pend;
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    tick(2);
    chk("t5_accepted", 128'(acc), 128'd32);
    chk("t5_max_pending_le2", 128'(maxpend <= 2), 128'd1);
    chk("t5_nbeats", 128'(beats.size()), 128'd32);
    bad = 0;
    for (int k = 0; k < 32; k++)
      if (beats[k].d !== pat(13'(k)) || beats[k].k !== 4'b1111 || beats[k].l !== (k == 31)) bad++;
    chk("t5_beat_stream", 128'(bad), 128'd0);

    // ---- reset mid-readout, then a stale completion ----
    do_reset();
    out_ready = 1'b0;
    send_cmd(64'h0, 16'd128);
    wait_reqs("t6_nreq", 1);
    pulse(5'd0);
    tick(6);
    @(negedge clk);
    chk("t6_stalled_valid", 128'(out_valid), 128'd1);
    chk("t6_stalled_no_rd", 128'(ram_rd_en), 128'd0);
    tick(1);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    out_ready = 1'b1;
    pulse(5'd0);
    ov = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid || ram_rd_en) ov++;
    end
    chk("t6_no_output", 128'(ov), 128'd0);
    chk("t6_busy", 128'(busy), 128'd0);
    chk("t6_ready_valid", {126'd0, cmd_ready, req_valid}, {126'd0, 1'b1, 1'b0});
    chk("t6_out_data", out_data, 128'd0);
    chk("t6_out_keep_last", {123'd0, out_keep, out_last}, 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/dma_rd_tag_ctrl.md
# dma_rd_tag_ctrl

DMA read scheduler for the PCIe DMA read path. It splits host read commands into memory-read requests of at most MAX_RD_DW dwords and allocates one of 32 completion tags per request. It tracks per-tag completion via the RX completion RAM's `tag_rc_done`, then reads each tag's buffered data out of that RAM in issue order as a 128-bit user stream.

## Interface
- MAX_RD_DW, 128: maximum dwords per read request; power of two, 4..128 (a tag slot holds 32 rows × 4 DW).
- TAG_NUM, 32: tags in pool; fixed to 32 (5-bit tag).
- clk  in  1  single clock (125 MHz); everything synchronous to it.
- rst  in  1  synchronous reset, active-high.
- cmd_valid  in  1  read command valid.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_addr  in  64  host byte address, DW aligned (bits[1:0] ignored).
- cmd_len_dw  in  16  command length in dwords, 1..65535 (0 treated as 1).
- req_valid  out  1  read request to TX TLP builder.
- req_ready  in  1  request consumed when req_valid && req_ready.
- req_addr  out  64  request byte address.
- req_len  out  11  request length in DW, 1..MAX_RD_DW.
- req_tag  out  5  allocated tag.
- tag_rc_done  in  1  one-cycle pulse: tag fully received into RAM.
- tag_rc_number  in  5  tag completed with tag_rc_done.
- ram_rd_en  out  1  RX RAM read enable.
- ram_rd_addr  out  13  {3'b000, tag[4:0], row[4:0]}.
- ram_rd_data  in  128  RAM data, valid exactly 1 cycle after ram_rd_en.
- out_valid  out  1  user data beat valid.
- out_ready  in  1  user back-pressure.
- out_data  out  128  data, DW0 in bits[31:0].
- out_keep  out  4  valid DWs, contiguous from bit 0; 4'b1111 except on the last beat of a tag.
- out_last  out  1  last beat of a command.
- busy  out  1  any command, request or tag outstanding.

## Operation
- Request FSM: IDLE -> ISSUE -> IDLE.
  - IDLE: cmd_ready=1. On accept, latch addr/len and go to ISSUE.
  - ISSUE: cmd_ready=0. req_len = min(remaining, MAX_RD_DW − (addr_dw mod MAX_RD_DW)), so no request crosses a MAX_RD_DW-DW boundary.
  - req_valid is asserted only while the outstanding count is below 32. Fields are held stable until handshake.
  - On handshake: addr += 4·req_len, remaining −= req_len; record per-tag length and last-of-command flag. Return to IDLE when remaining reaches 0.
- Tags are allocated circularly via alloc_ptr (0..31, wraps 31->0). outstanding = allocated, not yet retired.
- done[31:0]: tag_rc_done sets done[tag_rc_number] only if that tag is outstanding; otherwise the pulse is ignored.
- Readout FSM: R_IDLE -> R_READ -> R_IDLE.
  - R_IDLE: wait for done[retire_ptr].
  - R_READ: issue rows 0..ceil(len/4)−1 of retire_ptr.
  - After the final row: clear done bit, retire_ptr++ (wraps), outstanding−−.
- Output: a 2-entry skid FIFO. ram_rd_en is asserted only if FIFO occupancy plus in-flight reads is below 2, so no data is lost under out_ready=0.
- Last beat of a tag: out_keep = len mod 4 (0 -> 4'b1111). out_last = that tag's last-of-command flag.
- Simultaneous allocate and retire in one cycle: outstanding unchanged.
- busy = (request FSM ≠ IDLE) || outstanding≠0 || FIFO not empty.

## Timing
- Reset values: cmd_ready=1, req_valid=0, req_addr=0, req_len=0, req_tag=0, ram_rd_en=0, ram_rd_addr=0, out_valid=0, out_data=0, out_keep=0, out_last=0, busy=0. Pointers, count, done and FIFO are cleared.
- Reset mid-operation: all in-flight state is abandoned. Stale tag_rc_done pulses after reset are ignored because no tag is outstanding.
- First req_valid is asserted the cycle after command accept. Back-to-back requests are issued on consecutive cycles while req_ready=1.
- tag_rc_done at cycle T: done bit set at T+1, first ram_rd_en at T+1 (earliest), first out_valid at T+2.
- Sustained throughput: 1 beat/cycle with out_ready=1.
- A tag is freed the cycle after its last ram_rd_en and may be reallocated in that same cycle.

## Test plan
- Command addr=0x1000, len=4 DW -> one request (tag 0, len 4). Pulse done tag 0 -> one beat, keep=1111, last=1.
- Command addr=0x1F0, len=300, MAX_RD_DW=128 -> requests len 4 @0x1F0, 128 @0x200, 128 @0x400, 40 @0x600. Readout of tags 0..3: 1+32+32+10 beats; last beat keep=1111, out_last only on the final beat.
- Completions arrive out of order (tags 2, 0, 1) -> output stays in tag order 0, 1, 2. Readout starts only after tag 0 completes.
- 33 one-DW requests with no completions -> req_valid stalls after tag 31 is issued. Completing tag 0 -> retire, then tag 0 is reissued, showing wrap-around.
- out_ready toggling 1-0-0-1 during a 32-beat tag -> no lost or duplicated beats; ram_rd_en never leaves more than 2 beats pending.
- rst mid-readout, then a stale tag_rc_done -> outputs at reset values, no out_valid, busy=0.
